// File: rtl/alram_rdstream.sv
// Read sequencer behind the ECC RAM: issues credit-limited reads, absorbs RLAT, streams words out.
// Optional stall counter enabled by defining ALRAM_RDSTREAM_STALLCNT_EN.
module alram_rdstream #(
  parameter int WID  = 256,
  parameter int AWID = 5,
  parameter int RLAT = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [AWID-1:0] i_sa,
  input  logic [AWID:0]   i_len,
  output logic            o_busy,
  output logic            o_done,
  output logic [AWID-1:0] o_ra,
  input  logic [WID-1:0]  i_rdi,
  output logic [WID-1:0]  o_odat,
  output logic            o_ovld,
  input  logic            i_ordy,
  output logic [15:0]     o_stallcnt
);
  localparam int FD = RLAT + 2;
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(FD + 1);
  localparam logic [CW:0]   FD_C = (CW+1)'(FD);
  localparam logic [PW-1:0] LAST = PW'(FD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          r_state;
  logic [AWID:0]   r_rem;
  logic [AWID-1:0] r_ra;
  logic            r_busy, r_done;
  logic [RLAT:1]   r_vld_pipe;
  logic [WID-1:0]  r_mem [FD];
  logic [PW-1:0]   r_rp, r_wp;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_infl;
  logic            w_push, w_pop, w_issue;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_infl = '0;
    for (int k = 1; k <= RLAT; k++) w_infl = w_infl + CW'(r_vld_pipe[k]);
  end

  assign o_ovld    = (r_cnt != '0);
  assign o_odat    = r_mem[r_rp];
  assign o_ra      = r_ra;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign w_push    = r_vld_pipe[RLAT];
  assign w_pop     = o_ovld & i_ordy;
  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
  // Credits use registered occupancy only, so a pop frees a slot one cycle later.
  assign w_issue   = (r_state == S_RUN) && (r_rem != '0) &&
                     (({1'b0, r_cnt} + {1'b0, w_infl}) < FD_C);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ra    <= '0;
      r_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          if (i_len != '0) begin
            r_ra    <= i_sa;
            r_rem   <= i_len;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_done <= 1'b1;
          end
        end
        S_RUN: if (w_issue) begin
          r_ra  <= r_ra + 1'b1;
          r_rem <= r_rem - 1'b1;
          if (r_rem == (AWID+1)'(1)) r_state <= S_DRAIN;
        end
        // Leave when the final pop happens this cycle so done lands right after it.
        S_DRAIN: if (w_infl == '0 && w_cnt_nxt == '0) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
      r_cnt      <= '0;
      r_rp       <= '0;
      r_wp       <= '0;
    end else begin
      r_vld_pipe[1] <= w_issue;
      for (int k = 2; k <= RLAT; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
      if (w_push) r_wp <= nxt(r_wp);
      if (w_pop)  r_rp <= nxt(r_rp);
      r_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_rdi;
  end

`ifdef ALRAM_RDSTREAM_STALLCNT_EN
  logic        w_accept;
  logic [15:0] r_stall;
  assign w_accept = (r_state == S_IDLE) && i_start;
  always_ff @(posedge i_clk) begin
    if (i_rst || w_accept)
      r_stall <= '0;
    else if (o_ovld && !i_ordy && r_stall != 16'hFFFF)
      r_stall <= r_stall + 16'd1;
  end
  assign o_stallcnt = r_stall;
`else
  assign o_stallcnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alram_rdstream.sv
// Randomized bench for alram_rdstream: three instances (RLAT 1..3) share stimulus and are
// scored against an address-order stream model and the documented cycle timing.
module tb_alram_rdstream;
  localparam int WID = 256, AWID = 5, DEP = 32, NI = 3;

  logic            clk = 1'b0;
  logic            rst, start, ordy;
  logic [AWID-1:0] sa;
  logic [AWID:0]   len;
  logic            busy [NI], done [NI], ovld [NI];
  logic [AWID-1:0] ra   [NI];
  logic [WID-1:0]  rdi  [NI], odat [NI];
  logic [15:0]     stc  [NI];
  logic [WID-1:0]  mem  [DEP];
  logic [WID-1:0]  rsh  [NI][3];

  int nerr = 0, nchk = 0, cyc = 0;
  int act [NI], base [NI], clen [NI], got [NI], fo [NI], dc [NI], dn [NI], stl [NI], st [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    alram_rdstream #(.WID(WID), .AWID(AWID), .RLAT(g + 1)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_sa(sa), .i_len(len),
      .o_busy(busy[g]), .o_done(done[g]), .o_ra(ra[g]), .i_rdi(rdi[g]),
      .o_odat(odat[g]), .o_ovld(ovld[g]), .i_ordy(ordy), .o_stallcnt(stc[g]));
  end

  // RAM model: data for address driven in cycle t appears in cycle t+RLAT.
  always @(posedge clk)
    for (int i = 0; i < NI; i++) begin
      rsh[i][2] <= rsh[i][1];
      rsh[i][1] <= rsh[i][0];
      rsh[i][0] <= mem[ra[i]];
    end
  always_comb
    for (int i = 0; i < NI; i++) rdi[i] = rsh[i][i];

  task automatic chk(input string tag, input int inst, input logic [WID-1:0] got_v,
                     input logic [WID-1:0] exp_v);
    nchk++;
    if (got_v !== exp_v) begin
      nerr++;
      $display("FAIL %s (rlat=%0d) cyc %0d: got %0h expected %0h", tag, inst + 1, cyc, got_v, exp_v);
    end
  endtask

  // Reference stream model: the k-th accepted word of a command must be mem[(sa+k) % DEP].
  always @(negedge clk) begin : mon
    int rel;
    for (int i = 0; i < NI; i++) begin
      if (rst) act[i] = 0;
      else if (start && !busy[i]) begin
        act[i] = 1; base[i] = int'(sa); clen[i] = int'(len); got[i] = 0;
        fo[i] = -1; dc[i] = -1; dn[i] = 0; stl[i] = 0; st[i] = cyc;
      end else if (act[i] != 0) begin
        rel = cyc - st[i];
        if (ovld[i] && fo[i] < 0) fo[i] = rel;
        if (ovld[i] && !ordy) stl[i]++;
        if (ovld[i] && ordy) begin
          chk("word_extra", i, WID'(got[i] < clen[i]), WID'(1));
          chk("odat", i, odat[i], mem[(base[i] + got[i]) % DEP]);
          got[i]++;
        end
        if (done[i]) begin
          dn[i]++;
          if (dc[i] < 0) dc[i] = rel;
          chk("done_with_ovld", i, WID'(ovld[i]), WID'(0));
        end
        if (busy[i] && clen[i] < DEP)
          chk("ra_lead", i, WID'(((int'(ra[i]) - base[i] - got[i] + 2 * DEP) % DEP) <= i + 3), WID'(1));
      end else if (ovld[i]) chk("stray_ovld", i, WID'(ovld[i]), WID'(0));
    end
  end

  // mode 0: ordy=1, mode 1: ordy 1,0,0,0 repeating, mode 2: random ordy.
  task automatic run_cmd(input int s, input int l, input int mode, input int rst_at, input int ign_at);
    int n;
    bit fin;
    @(posedge clk); #1;
    start = 1'b1; sa = AWID'(s); len = (AWID+1)'(l); ordy = 1'b1;
    n = 0; fin = 1'b0;
    while (!fin && n < 500) begin
      @(posedge clk); #1;
      n++;
      start = (n == ign_at);
      if (n == ign_at) begin sa = AWID'(s + 7); len = (AWID+1)'(3); end
      rst = (n == rst_at);
      case (mode)
        0:       ordy = 1'b1;
        1:       ordy = ((n - 1) % 4 == 0);
        default: ordy = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk); #1;
      if (rst_at > 0) begin
        if (n == rst_at + 1) begin
          for (int i = 0; i < NI; i++) begin
            chk("rst_busy", i, WID'(busy[i]), WID'(0));
            chk("rst_ovld", i, WID'(ovld[i]), WID'(0));
            chk("rst_done", i, WID'(done[i]), WID'(0));
            chk("rst_stallcnt", i, WID'(stc[i]), WID'(0));
          end
          fin = 1'b1;
        end
      end else begin
        fin = 1'b1;
        for (int i = 0; i < NI; i++) if (dn[i] == 0) fin = 1'b0;
      end
    end
    chk("timeout", 0, WID'(fin), WID'(1));
    if (rst_at <= 0) begin
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        chk("done_cnt", i, WID'(dn[i]), WID'(1));
        chk("words", i, WID'(got[i]), WID'(l));
        chk("busy_end", i, WID'(busy[i]), WID'(0));
`ifdef ALRAM_RDSTREAM_STALLCNT_EN
        chk("stallcnt", i, WID'(stc[i]), WID'(stl[i]));
`else
        chk("stallcnt", i, WID'(stc[i]), WID'(0));
`endif
        if (mode == 0) begin
          chk("first_ovld", i, WID'(fo[i]), WID'((l == 0) ? -1 : i + 3));
          chk("done_cyc", i, WID'(dc[i]), WID'((l == 0) ? 1 : l + i + 3));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ordy = 1'b1; sa = '0; len = '0;
    for (int a = 0; a < DEP; a++)
      for (int w = 0; w < WID / 32; w++) mem[a][w*32 +: 32] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("reset_busy", i, WID'(busy[i]), WID'(0));
      chk("reset_done", i, WID'(done[i]), WID'(0));
      chk("reset_ovld", i, WID'(ovld[i]), WID'(0));
      chk("reset_ra", i, WID'(ra[i]), WID'(0));
      chk("reset_stallcnt", i, WID'(stc[i]), WID'(0));
    end
    rst = 1'b0;
    run_cmd(3, 8, 0, -1, -1);     // full rate
    run_cmd(30, 4, 0, -1, -1);    // wrap-around
    run_cmd(0, 10, 1, -1, -1);    // backpressure
    run_cmd(5, 0, 0, -1, -1);     // zero length
    run_cmd(12, 8, 0, -1, 3);     // start while busy is ignored
    run_cmd(9, 16, 1, 6, -1);     // reset mid-command
    run_cmd(20, 6, 0, -1, -1);    // fresh start after reset
    run_cmd(0, 5, 0, -1, -1);     // latency sweep across instances
    run_cmd(0, 32, 1, -1, -1);    // full depth
    for (int t = 0; t < 10; t++)
      run_cmd(int'($urandom_range(0, DEP - 1)), int'($urandom_range(1, DEP)), 2, -1, -1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
